// File: rtl/drv_ad747x_pkg.sv
// Shared types and constants for the AD747x serial ADC reader.
// The SCLK period generator is kept generic so the DAC driver can reuse it.
package drv_ad747x_pkg;

  localparam int FRAME_BITS = 16;
  localparam int LEAD_ZEROS = 4;

  localparam string SIGN_SIGNED   = "SIGNED";
  localparam string SIGN_UNSIGNED = "UNSIGNED";

  typedef logic [FRAME_BITS-1:0] frame_t;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    QUIET
  } state_t;

endpackage

// File: rtl/drv_ad747x_sclk_gen.sv
// Free-running SCLK period counter with boundary and rising-edge strikes.
// wrap marks the last cycle of a period, so the next cycle is a boundary.
module sclk_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic wrap,
  output logic rise,
  output logic hi_nxt
);

  localparam int CW   = $clog2(DIV);
  localparam int HALF = DIV / 2;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)     cnt <= '0;
    else if (wrap) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  assign wrap   = (cnt == CW'(DIV - 1));
  assign rise   = (cnt == CW'(HALF - 1));
  // sclk level for the following cycle, so the output can be registered
  assign hi_nxt = !wrap && (rise || (cnt > CW'(HALF - 1)));

endmodule

// File: rtl/drv_ad747x.sv
// AD7476/7477/7478 serial ADC reader: CS/SCLK framing, deserialiser,
// and an Avalon-ST source that holds each sample until accepted.
module drv_ad747x
  import drv_ad747x_pkg::*;
#(
  parameter int    DATA_WIDTH     = 12,
  parameter string SIGN           = "UNSIGNED",
  parameter int    SCLK_DIVIDER   = 4,
  parameter int    QUIET_DURATION = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  trigStart,
  output logic                  trigDrop,
  output logic                  asoValid,
  output logic [DATA_WIDTH-1:0] asoData,
  input  logic                  asoRdy,
  output logic                  asoOvf,
  output logic                  adcCs,
  output logic                  adcSclk,
  input  logic                  adcSdata
);

  if (SCLK_DIVIDER < 2 || (SCLK_DIVIDER % 2) != 0) begin : g_bad_div
    $error("SCLK_DIVIDER must be even and >= 2");
  end
  if (QUIET_DURATION < 1) begin : g_bad_quiet
    $error("QUIET_DURATION must be >= 1");
  end
  if (DATA_WIDTH != 12 && DATA_WIDTH != 10 && DATA_WIDTH != 8) begin : g_bad_dw
    $error("DATA_WIDTH must be 12, 10 or 8");
  end

  localparam int   MSB   = FRAME_BITS - LEAD_ZEROS - 1;
  localparam int   QW    = $clog2(QUIET_DURATION);
  localparam int   PW    = (QW > 4) ? QW : 4;
  localparam logic [PW-1:0] CLAST = PW'(FRAME_BITS - 1);
  localparam logic [PW-1:0] QLAST = PW'(QUIET_DURATION - 1);
  localparam logic IS_SIGNED = (SIGN == SIGN_SIGNED);

  logic wrap, rise, hi_nxt;

  sclk_gen #(
    .DIV(SCLK_DIVIDER)
  ) u_sclk (
    .clk   (clk),
    .reset (reset),
    .wrap  (wrap),
    .rise  (rise),
    .hi_nxt(hi_nxt)
  );

  state_t          state, state_nxt;
  logic [PW-1:0]   pcnt, pcnt_nxt;
  logic            pending, launch;
  logic            cap, done;
  frame_t          shreg;
  logic            cs_q, sclk_q;
  logic [DATA_WIDTH-1:0] sample;
  logic            frame_unused;

  assign cap = (state == CONV) && rise;

  always_comb begin
    state_nxt = state;
    pcnt_nxt  = pcnt;
    launch    = 1'b0;
    unique case (state)
      IDLE: begin
        if (wrap && pending) begin
          state_nxt = CONV;
          pcnt_nxt  = '0;
          launch    = 1'b1;
        end
      end
      CONV: begin
        if (wrap) begin
          if (pcnt == CLAST) begin
            state_nxt = QUIET;
            pcnt_nxt  = '0;
          end else begin
            pcnt_nxt = pcnt + 1'b1;
          end
        end
      end
      QUIET: begin
        if (wrap) begin
          pcnt_nxt = pcnt + 1'b1;
          if (pcnt == QLAST) begin
            // a strobe held during the frame starts the next one at once
            state_nxt = pending ? CONV : IDLE;
            launch    = pending;
            pcnt_nxt  = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pcnt     <= '0;
      cs_q     <= 1'b1;
      sclk_q   <= 1'b1;
      pending  <= 1'b0;
      trigDrop <= 1'b0;
      done     <= 1'b0;
      shreg    <= '0;
    end else begin
      state    <= state_nxt;
      pcnt     <= pcnt_nxt;
      cs_q     <= (state_nxt != CONV);
      sclk_q   <= (state_nxt != CONV) || hi_nxt;
      trigDrop <= trigStart && pending;
      if (trigStart && !pending) pending <= 1'b1;
      else if (launch)           pending <= 1'b0;
      done <= cap && (pcnt == CLAST);
      if (cap) shreg <= {shreg[FRAME_BITS-2:0], adcSdata};
    end
  end

  assign sample = shreg[MSB -: DATA_WIDTH]
                ^ {IS_SIGNED, {(DATA_WIDTH-1){1'b0}}};
  assign frame_unused = ^shreg;

  always_ff @(posedge clk) begin
    if (reset) begin
      asoValid <= 1'b0;
      asoData  <= '0;
      asoOvf   <= 1'b0;
    end else begin
      asoOvf <= done && asoValid && !asoRdy;
      if (done) begin
        asoValid <= 1'b1;
        asoData  <= sample;
      end else if (asoRdy) begin
        asoValid <= 1'b0;
      end
    end
  end

  assign adcCs   = cs_q;
  assign adcSclk = sclk_q;

endmodule

// File: tb/tb_drv_ad747x.sv
// Directed bench for drv_ad747x: three widths/sign variants share one
// ADC model and trigger; expected values are hand-computed constants.
module tb_drv_ad747x;

  localparam int D = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic trig = 1'b0;
  logic rdy = 1'b0;
  logic sdata;

  logic dropA, validA, ovfA, csA, sclkA;
  logic dropS, validS, ovfS, csS, sclkS;
  logic dropB, validB, ovfB, csB, sclkB;
  logic [11:0] dataA, dataS;
  logic [9:0]  dataB;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ref_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  drv_ad747x #(.DATA_WIDTH(12), .SIGN("UNSIGNED"),
               .SCLK_DIVIDER(D), .QUIET_DURATION(2)) u_a (
    .clk(clk), .reset(reset), .trigStart(trig), .trigDrop(dropA),
    .asoValid(validA), .asoData(dataA), .asoRdy(rdy), .asoOvf(ovfA),
    .adcCs(csA), .adcSclk(sclkA), .adcSdata(sdata));

  drv_ad747x #(.DATA_WIDTH(12), .SIGN("SIGNED"),
               .SCLK_DIVIDER(D), .QUIET_DURATION(2)) u_s (
    .clk(clk), .reset(reset), .trigStart(trig), .trigDrop(dropS),
    .asoValid(validS), .asoData(dataS), .asoRdy(rdy), .asoOvf(ovfS),
    .adcCs(csS), .adcSclk(sclkS), .adcSdata(sdata));

  drv_ad747x #(.DATA_WIDTH(10), .SIGN("UNSIGNED"),
               .SCLK_DIVIDER(D), .QUIET_DURATION(2)) u_b (
    .clk(clk), .reset(reset), .trigStart(trig), .trigDrop(dropB),
    .asoValid(validB), .asoData(dataB), .asoRdy(rdy), .asoOvf(ovfB),
    .adcCs(csB), .adcSclk(sclkB), .adcSdata(sdata));

  // ADC model plus frame monitor, sampled mid-cycle
  logic [15:0] next_fr = '0;
  logic [15:0] cur = '0;
  int   bi = -1;
  logic psclk = 1'b1, pcs = 1'b1, pval = 1'b0;
  int   n_fall = 0, n_low = 0, n_rise = 0, n_drop = 0, n_ovf = 0;
  int   fall_cyc = 0, rise_cyc = 0, val_cyc = 0, gap = 0;

  assign sdata = (bi >= 0 && bi < 16) ? cur[15 - bi] : 1'b0;

  always @(negedge clk) begin
    psclk <= sclkA;
    pcs   <= csA;
    pval  <= validA;
    if (csA) bi <= -1;
    else if (psclk && !sclkA) bi <= bi + 1;
    if (pcs && !csA) begin
      cur      <= next_fr;
      n_fall   <= n_fall + 1;
      fall_cyc <= cyc;
      gap      <= cyc - rise_cyc;
    end
    if (!pcs && csA) rise_cyc <= cyc;
    if (!csA) n_low <= n_low + 1;
    if (!csA && !psclk && sclkA) n_rise <= n_rise + 1;
    if (validA && !pval) val_cyc <= cyc;
    n_drop <= n_drop + int'(dropA);
    n_ovf  <= n_ovf + int'(ovfA);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // pulse trig in a cycle where cnt==2; returns the strobe cycle
  task automatic strobe(output int ts);
    @(negedge clk);
    while (((cyc - ref_cyc) % D) != 2) @(negedge clk);
    ts   = cyc;
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic one_frame(input string tag, input logic [15:0] f,
                           input logic [11:0] ea, input logic [11:0] es,
                           input logic [9:0] eb);
    int f0, l0, r0, ts;
    next_fr = f;
    f0 = n_fall; l0 = n_low; r0 = n_rise;
    strobe(ts);
    repeat (100) @(negedge clk);
    chk({tag, ":frames"}, n_fall - f0, 1);
    chk({tag, ":cs_lat"}, fall_cyc - ts, 2);
    chk({tag, ":cs_len"}, n_low - l0, 64);
    chk({tag, ":sclk"}, n_rise - r0, 16);
    chk({tag, ":val_lat"}, val_cyc - fall_cyc, 63);
    chk({tag, ":valid"}, validA, 1);
    chk({tag, ":dataA"}, dataA, ea);
    chk({tag, ":dataS"}, dataS, es);
    chk({tag, ":dataB"}, dataB, eb);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    chk({tag, ":consumed"}, validA, 0);
  endtask

  initial begin
    int ts, f0, d0, o0;
    repeat (3) @(negedge clk);
    chk("rst:cs", csA, 1);
    chk("rst:sclk", sclkA, 1);
    chk("rst:valid", validA, 0);
    chk("rst:data", dataA, 0);
    chk("rst:drop", dropA, 0);
    chk("rst:ovf", ovfA, 0);
    ref_cyc = cyc;
    reset = 1'b0;

    one_frame("u_a5c", 16'h0A5C, 12'hA5C, 12'h25C, 10'h297);
    one_frame("zero", 16'h0000, 12'h000, 12'h800, 10'h000);
    one_frame("pad", 16'h5CCF, 12'hCCF, 12'h4CF, 10'h333);

    // two strobes 3 cycles apart, third during CONV, sink stalled
    next_fr = 16'h0123;
    f0 = n_fall; d0 = n_drop; o0 = n_ovf;
    strobe(ts);
    repeat (2) @(negedge clk);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    repeat (16) @(negedge clk);
    next_fr = 16'h0456;
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    repeat (200) @(negedge clk);
    chk("b2b:frames", n_fall - f0, 2);
    chk("b2b:drop", n_drop - d0, 1);
    chk("b2b:gap_min", gap >= 8, 1);
    chk("b2b:second_at", fall_cyc - ts, 74);
    chk("b2b:ovf", n_ovf - o0, 1);
    chk("b2b:valid", validA, 1);
    chk("b2b:dataA", dataA, 12'h456);
    chk("b2b:dataS", dataS, 12'hC56);
    chk("b2b:dataB", dataB, 10'h115);

    // accept the old sample on the very cycle the new one loads
    next_fr = 16'h0789;
    o0 = n_ovf;
    strobe(ts);
    repeat (63) @(negedge clk);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    chk("race:valid", validA, 1);
    chk("race:dataA", dataA, 12'h789);
    repeat (20) @(negedge clk);
    chk("race:ovf", n_ovf - o0, 0);

    // reset during period 7 of a frame
    next_fr = 16'h0FFF;
    strobe(ts);
    repeat (29) @(negedge clk);
    chk("mid:cs_low", csA, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid:cs", csA, 1);
    chk("mid:sclk", sclkA, 1);
    chk("mid:valid", validA, 0);
    ref_cyc = cyc;
    reset = 1'b0;
    repeat (80) @(negedge clk);
    chk("mid:no_partial", validA, 0);
    one_frame("after_rst", 16'h0ABC, 12'hABC, 12'h2BC, 10'h2AF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/drv_ad747x.md
# drv_ad747x

Serial ADC reader for the AD7476/AD7477/AD7478 family (12/10/8 bits, single channel, CS-framed, 16 SCLK per conversion). It is the capture-side counterpart of the dual-channel DAC driver. A sampling strobe starts each conversion. The block runs the CS/SCLK frame, deserialises SDATA and presents each sample on an Avalon-ST source held until it is accepted.

## Interface
Parameters:
- DATA_WIDTH, 12: ADC resolution. Legal values 12, 10, 8.
- SIGN, "UNSIGNED": "SIGNED" inverts the MSB, converting straight binary to two's complement.
- SCLK_DIVIDER, 4: clk cycles per SCLK period. Must be even and ≥ 2; any other value is an elaboration-time `$error`.
- QUIET_DURATION, 2: minimum number of SCLK periods with CS high between frames. Must be ≥ 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- trigStart  in  1  one-cycle sampling strobe.
- trigDrop  out  1  one-cycle pulse: a strobe was lost because one was already pending.
- asoValid  out  1  sample available.
- asoData  out  DATA_WIDTH  sample value.
- asoRdy  in  1  sink accepts the sample.
- asoOvf  out  1  one-cycle pulse: an unaccepted sample was overwritten.
- adcCs  out  1  active-low conversion frame.
- adcSclk  out  1  serial clock; idles high.
- adcSdata  in  1  ADC serial data.

## Operation
- Period counter `cnt` runs 0..SCLK_DIVIDER-1 freely from reset. A period boundary is the cycle where `cnt`==0.
- During a frame, adcSclk is low for `cnt` < SCLK_DIVIDER/2 and high otherwise. Outside a frame it is high.
- Trigger latch: trigStart sets `pending`.
  - If `pending` is already set, trigDrop pulses and the extra strobe is discarded.
  - `pending` clears when the frame it launched starts.
- FSM states:
  - IDLE: adcCs=1. On a period boundary with `pending`=1, go to CONV.
  - CONV: adcCs=0 for exactly 16 SCLK periods, numbered 0..15. Bit i is captured from adcSdata on the clk edge that drives adcSclk high in period i and shifted MSB-first into a 16-bit register. After period 15, go to QUIET.
  - QUIET: adcCs=1 for QUIET_DURATION full periods, then go to IDLE.
- Frame format: 4 leading zeros, then data MSB first, then zero padding. Extraction is `asoData = frame[11 -: DATA_WIDTH]`, with the MSB inverted when SIGN=="SIGNED". Leading and padding bits are ignored, not checked.
- Output register:
  - The sample loads one clk cycle after the last capture and asoValid goes to 1.
  - On asoValid & asoRdy, asoValid goes to 0 on the next cycle.
  - If a new sample loads while asoValid=1 and asoRdy=0, the data is overwritten, asoValid stays 1 and asoOvf pulses.
  - If the load cycle coincides with asoValid & asoRdy, the old sample is consumed, the new one loads, and asoOvf stays 0.
- trigStart arriving during CONV or QUIET sets `pending`. The next frame then starts at the first period boundary after QUIET ends.

## Timing
- Reset values: adcCs=1, adcSclk=1, asoValid=0, asoData=0, trigDrop=0, asoOvf=0, `pending`=0, `cnt`=0, FSM=IDLE.
- Reset asserted mid-frame: adcCs=1 and adcSclk=1 from the next clk edge; the partial sample is discarded.
- Trigger latency: trigStart at cycle t sets `pending` at t+1. adcCs falls at the first period boundary at or after t+1, so within SCLK_DIVIDER cycles when in IDLE.
- Frame length: adcCs stays low for 16·SCLK_DIVIDER cycles.
- Sample latency: asoValid rises 16·SCLK_DIVIDER − SCLK_DIVIDER/2 + 1 cycles after adcCs falls.
- Maximum rate: one sample per (16+QUIET_DURATION)·SCLK_DIVIDER cycles.
- adcSdata is sampled SCLK_DIVIDER/2 clk cycles after the falling SCLK edge, which provides the data-valid margin. No synchroniser is added; SCLK is derived from clk.

## Structure
- Shared package `drv_ad747x_pkg`:
  - `frame_t` (16-bit frame type)
  - FRAME_BITS=16
  - LEAD_ZEROS=4
  - FSM enum {IDLE, CONV, QUIET}
  - the SIGN string constants
- One sub-module, `sclk_gen`: the period counter. Outputs a boundary strike, the rise strike and the phase used for adcSclk. It is reusable by the DAC driver.
- All other logic stays flat in `drv_ad747x`.

## Test plan
All scenarios use SCLK_DIVIDER=4, QUIET_DURATION=2, and a bench ADC model that drives bits on falling SCLK edges.
- DATA_WIDTH=12, UNSIGNED, model value 0xA5C, single trigStart → one 64-cycle adcCs-low frame with 16 SCLK pulses; asoValid rises 63 cycles after adcCs falls; asoData=0xA5C.
- SIGNED, same model value 0xA5C → asoData=0x25C. Model value 0x000 → asoData=0x800.
- DATA_WIDTH=10, model frame 0000_1100110011_00 → asoData=0x333, with the padding ignored.
- Two strobes 3 cycles apart, then a third during CONV:
  - the second strobe is held pending;
  - the third pulses trigDrop;
  - exactly two frames result, separated by ≥ 8 cycles of adcCs high.
- Back-to-back frames with asoRdy=0 → asoOvf pulses once and asoData holds the second value. Raising asoRdy on the load cycle instead gives asoOvf=0.
- Reset asserted during period 7 of CONV → adcCs=1 and adcSclk=1 on the next edge; asoValid=0; the next trigger produces a clean frame.
